// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Immediate-format select encoding shared between the control
//               decoder and the immediate-generation stage.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

  typedef logic [2:0] imm_src_t;

  localparam imm_src_t IMM_I   = 3'b000;  // loads, ALU-immediate, jalr
  localparam imm_src_t IMM_S   = 3'b001;  // stores
  localparam imm_src_t IMM_B   = 3'b010;  // conditional branches
  localparam imm_src_t IMM_J   = 3'b011;  // jal
  localparam imm_src_t IMM_U   = 3'b100;  // lui / auipc
  localparam imm_src_t IMM_Z   = 3'b101;  // CSR zimm
  localparam imm_src_t IMM_SH  = 3'b110;  // shift amount
  localparam imm_src_t IMM_RSV = 3'b111;  // reserved, flagged illegal

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Combinational immediate extraction and extension.
//   instr   in  25    instruction bits [31:7] (port bit i = instr bit i+7)
//   imm_src in  3     format select (imm_pkg encoding)
//   imm     out XLEN  extended immediate
//   illegal out 1     reserved select used
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     instr,
  input  imm_src_t        imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Index map used below: instruction bit k lives at instr[k-7].
  // The sized casts of $signed operands perform the sign extension to XLEN.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:  imm = XLEN'($signed(instr[24:13]));
      IMM_S:  imm = XLEN'($signed({instr[24:18], instr[4:0]}));
      IMM_B:  imm = XLEN'($signed({instr[24], instr[0], instr[23:18],
                                   instr[4:1], 1'b0}));
      IMM_J:  imm = XLEN'($signed({instr[24], instr[12:5], instr[13],
                                   instr[23:14], 1'b0}));
      IMM_U:  imm = XLEN'($signed({instr[24:5], 12'b0}));
      IMM_Z:  imm = XLEN'(instr[12:8]);
      IMM_SH: begin
        // RV64 shifts use a 6-bit shamt; RV32 only 5 bits.
        if (XLEN == 64) imm = XLEN'(instr[18:13]);
        else            imm = XLEN'(instr[17:13]);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule : imm_decode
`default_nettype wire

// File: rtl/imm_extend_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_stage
// Description : Registered immediate-generation pipeline stage with a
//               valid/ready handshake and a one-entry skid buffer.
//   clk, reset          clock, synchronous active-high reset
//   flush               drop all held beats and the beat offered this cycle
//   in_valid/in_ready   input handshake (in_ready is registered)
//   in_instr            instruction bits [31:7]
//   in_imm_src          immediate format select
//   in_tag              sideband tag passed through unchanged
//   out_valid/out_ready output handshake
//   out_imm/out_tag     extended immediate and its tag
//   out_illegal         beat used the reserved format select
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  imm_src_t         in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             main_ill_q,   main_ill_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_ill_q,   skid_ill_d;

  logic accept;
  logic drain;

  // in_ready comes straight from the skid flop, so it never depends
  // combinationally on out_ready.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_tag_d   = main_tag_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (drain) begin
        if (skid_valid_q) begin
          main_valid_d = 1'b1;
          main_imm_d   = skid_imm_q;
          main_tag_d   = skid_tag_q;
          main_ill_d   = skid_ill_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      // accept implies skid is empty, so it never races the skid->main move.
      if (accept) begin
        if (!main_valid_q || drain) begin
          main_valid_d = 1'b1;
          main_imm_d   = dec_imm;
          main_tag_d   = in_tag;
          main_ill_d   = dec_illegal;
        end else begin
          skid_valid_d = 1'b1;
          skid_imm_d   = dec_imm;
          skid_tag_d   = in_tag;
          skid_ill_d   = dec_illegal;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_imm     = main_imm_q;
  assign out_tag     = main_tag_q;
  assign out_illegal = main_ill_q;

endmodule : imm_extend_stage
`default_nettype wire

// File: tb/tb_imm_extend_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_stage
// Description : Self-checking bench for imm_extend_stage. Two instances
//               (XLEN=32 and XLEN=64) share one stimulus stream and are
//               compared against a FIFO-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [24:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [31:0] in_tag;

  logic        rdy32, val32, ill32;
  logic [31:0] imm32, tag32;
  logic        rdy64, val64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  always #5 clk = ~clk;

  imm_extend_stage #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(val32), .out_ready(out_ready), .out_imm(imm32),
    .out_tag(tag32), .out_illegal(ill32)
  );

  imm_extend_stage #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(val64), .out_ready(out_ready), .out_imm(imm64),
    .out_tag(tag64), .out_illegal(ill64)
  );

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [31:0] tag;
    logic        ill;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] seen_tags[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          last_accept;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference immediate from the instruction-set field definitions.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins,
                                          input logic [2:0] src, input int xlen);
    longint sv, hi, v;
    sv = longint'($signed(ins));
    v  = 0;
    case (src)
      3'd0: v = sv >>> 20;
      3'd1: begin hi = sv >>> 25; v = hi * 32 + longint'((ins >> 7) & 32'h1f); end
      3'd2: begin
        hi = sv >>> 31;
        v  = hi * 4096 + longint'((ins >> 7) & 1) * 2048
           + longint'((ins >> 25) & 32'h3f) * 32 + longint'((ins >> 8) & 32'hf) * 2;
      end
      3'd3: begin
        hi = sv >>> 31;
        v  = hi * 1048576 + longint'((ins >> 12) & 32'hff) * 4096
           + longint'((ins >> 20) & 1) * 2048 + longint'((ins >> 21) & 32'h3ff) * 2;
      end
      3'd4: begin hi = sv >>> 12; v = hi * 4096; end
      3'd5: v = longint'((ins >> 15) & 32'h1f);
      3'd6: v = (xlen == 64) ? longint'((ins >> 20) & 32'h3f)
                             : longint'((ins >> 20) & 32'h1f);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'hffff_ffff;
    return v;
  endfunction

  // One clock: update the FIFO model at the edge, compare #1 later.
  task automatic step();
    bit    pre_ready;
    beat_t b;
    logic [31:0] ins;
    @(posedge clk);
    pre_ready   = (sb.size() < 2);
    last_accept = 1'b0;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (sb.size() > 0 && out_ready) begin
        seen_tags.push_back(sb[0].tag);
        void'(sb.pop_front());
      end
      if (in_valid && pre_ready) begin
        ins     = {in_instr, 7'b0};
        b.imm32 = ref_imm(ins, in_imm_src, 32)[31:0];
        b.imm64 = ref_imm(ins, in_imm_src, 64);
        b.tag   = in_tag;
        b.ill   = (in_imm_src == 3'b111);
        sb.push_back(b);
        last_accept = 1'b1;
      end
    end
    #1;
    chk("out_valid32", 64'(val32), 64'(sb.size() > 0));
    chk("out_valid64", 64'(val64), 64'(sb.size() > 0));
    chk("in_ready32",  64'(rdy32), 64'(sb.size() < 2));
    chk("in_ready64",  64'(rdy64), 64'(sb.size() < 2));
    if (sb.size() > 0) begin
      chk("imm32", 64'(imm32), 64'(sb[0].imm32));
      chk("imm64", imm64, sb[0].imm64);
      chk("tag32", 64'(tag32), 64'(sb[0].tag));
      chk("tag64", 64'(tag64), 64'(sb[0].tag));
      chk("ill32", 64'(ill32), 64'(sb[0].ill));
      chk("ill64", 64'(ill64), 64'(sb[0].ill));
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_imm_src = '0; in_tag = '0;
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_imm32"}, 64'(imm32), 64'd0);
    chk({name, "_imm64"}, imm64, 64'd0);
    chk({name, "_tag"},   64'({tag32, tag64}), 64'd0);
    chk({name, "_ill"},   64'({ill32, ill64}), 64'd0);
    chk({name, "_rdy"},   64'({rdy32, rdy64}), 64'd3);
  endtask

  // Single beat with known constant results, checked one cycle after accept.
  task automatic directed(input string name, input logic [31:0] ins,
                          input logic [2:0] src, input logic [63:0] e32,
                          input logic [63:0] e64, input logic eill);
    idle_inputs();
    step();
    in_valid = 1'b1; in_instr = ins[31:7]; in_imm_src = src; in_tag = ins;
    step();
    chk({name, "_v"},   64'({val32, val64}), 64'd3);
    chk({name, "_32"},  64'(imm32), e32);
    chk({name, "_64"},  imm64, e64);
    chk({name, "_ill"}, 64'({ill32, ill64}), {62'd0, eill, eill});
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step(); step();
    check_zero_outputs("reset");
    idle_inputs();

    directed("fmt_I",  32'hFFF00093, 3'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    directed("fmt_B",  32'hFE000EE3, 3'd2, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    directed("fmt_J",  32'h800000EF, 3'd3, 64'hFFF0_0000, 64'hFFFF_FFFF_FFF0_0000, 1'b0);
    directed("fmt_U",  32'h80000537, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    directed("fmt_Z",  32'h000FD073, 3'd5, 64'h1F, 64'h1F, 1'b0);
    directed("fmt_SH", 32'h03F51513, 3'd6, 64'h1F, 64'h3F, 1'b0);
    directed("fmt_RSV",32'hFFFFFFFF, 3'd7, 64'h0, 64'h0, 1'b1);

    // Back-pressure: tags 1..6 offered continuously, 3-cycle stall.
    idle_inputs();
    step(); step();
    seen_tags.delete();
    begin
      int t   = 1;
      int cyc = 0;
      while (cyc < 40 && (t <= 6 || sb.size() > 0)) begin
        in_valid   = (t <= 6);
        in_tag     = t;
        in_instr   = 25'($urandom);
        in_imm_src = 3'($urandom);
        out_ready  = !(cyc >= 2 && cyc <= 4);
        step();
        if (last_accept) t++;
        cyc++;
      end
      chk("bp_count", 64'(seen_tags.size()), 64'd6);
      for (int i = 0; i < seen_tags.size(); i++)
        chk("bp_order", 64'(seen_tags[i]), 64'(i + 1));
    end

    // Flush with both registers full and a beat on offer.
    idle_inputs();
    out_ready = 1'b0; in_valid = 1'b1;
    in_tag = 32'h11; step();
    in_tag = 32'h22; step();
    in_tag = 32'h33; step();
    chk("flush_pre_rdy", 64'(rdy32), 64'd0);
    flush = 1'b1; in_tag = 32'hDEAD; step();
    chk("flush_val", 64'({val32, val64}), 64'd0);
    chk("flush_rdy", 64'({rdy32, rdy64}), 64'd3);
    idle_inputs();
    step(); step();

    // Reset mid-stream.
    out_ready = 1'b0; in_valid = 1'b1;
    in_tag = 32'h44; in_instr = 25'h1ff_ffff; step();
    in_tag = 32'h55; step();
    reset = 1'b1; step();
    check_zero_outputs("midreset");
    chk("midreset_val", 64'({val32, val64}), 64'd0);
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_tag = 32'h66;
    in_instr = 25'h0; in_imm_src = 3'd0;
    step();
    chk("postreset_lat", 64'({val32, val64}), 64'd3);
    chk("postreset_tag", 64'(tag32), 64'h66);
    idle_inputs();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_instr   = 25'($urandom);
      in_imm_src = 3'($urandom);
      in_tag     = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_imm_extend_stage
`default_nettype wire
